// File: rtl/usb_typec_attach_ctrl_if.sv
// ---------------------------------------------------------------------------
// usb_typec_attach_ctrl_if
// Pin-level bundle between the Type-C attach controller and its neighbours.
// The controller uses the slave modport. The CC comparators, VBUS monitor and
// authentication FSM (or a host model) use the master modport.
//
// Signals (direction as seen by the controller):
//   cc1_rd      in   CC1 termination detected (already synchronised)
//   cc2_rd      in   CC2 termination detected (already synchronised)
//   vbus_good   in   VBUS within valid range
//   auth_done   in   one-cycle pulse, authentication result valid
//   auth_pass   in   authentication result, only meaningful with auth_done
//   vbus_en     out  VBUS switch enable
//   orient      out  0 = CC1 active, 1 = CC2 active
//   auth_start  out  one-cycle pulse that kicks the authentication FSM
//   link_ready  out  attached, powered and authenticated
//   auth_locked out  authentication retries exhausted
//   state_o     out  current controller state encoding
//   retry_cnt   out  failed authentication attempts in this attach
// ---------------------------------------------------------------------------
interface usb_typec_attach_ctrl_if;
  logic       cc1_rd;
  logic       cc2_rd;
  logic       vbus_good;
  logic       auth_done;
  logic       auth_pass;
  logic       vbus_en;
  logic       orient;
  logic       auth_start;
  logic       link_ready;
  logic       auth_locked;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;

  modport slave (
    input  cc1_rd, cc2_rd, vbus_good, auth_done, auth_pass,
    output vbus_en, orient, auth_start, link_ready, auth_locked,
           state_o, retry_cnt
  );

  modport master (
    output cc1_rd, cc2_rd, vbus_good, auth_done, auth_pass,
    input  vbus_en, orient, auth_start, link_ready, auth_locked,
           state_o, retry_cnt
  );
endinterface

// File: rtl/usb_typec_attach_ctrl.sv
// ---------------------------------------------------------------------------
// usb_typec_attach_ctrl
// Device-side Type-C attach sequencer. It debounces a single-CC attach and
// latches the cable orientation. It then powers VBUS and waits for it to
// become good, and runs authentication with bounded retries and timeouts.
// Link-ready, lockout and error-recovery status are reported from here.
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   reset  in   synchronous, active-high
//   bus    slave side of usb_typec_attach_ctrl_if (CC/VBUS/auth handshake)
// ---------------------------------------------------------------------------
module usb_typec_attach_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned VBUS_TIMEOUT    = 8,
  parameter int unsigned AUTH_TIMEOUT    = 16,
  parameter int unsigned MAX_RETRIES     = 2,
  parameter int unsigned RECOVERY_CYCLES = 6
) (
  input logic                     clk,
  input logic                     reset,
  usb_typec_attach_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_UNATTACHED     = 3'd0,
    ST_ATTACH_WAIT    = 3'd1,
    ST_POWER_ON       = 3'd2,
    ST_AUTH_REQ       = 3'd3,
    ST_AUTH_WAIT      = 3'd4,
    ST_LINK_UP        = 3'd5,
    ST_LOCKOUT        = 3'd6,
    ST_ERROR_RECOVERY = 3'd7
  } state_t;

  // Terminal timer values, the last cycle spent in each timed state.
  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] VBUS_LAST = 16'(VBUS_TIMEOUT - 1);
  localparam logic [15:0] AUTH_LAST = 16'(AUTH_TIMEOUT - 1);
  localparam logic [15:0] REC_LAST  = 16'(RECOVERY_CYCLES - 1);
  localparam logic [3:0]  MAX_R     = 4'(MAX_RETRIES);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_timer;
  logic        r_orient;
  logic [3:0]  r_retry;
  logic [3:0]  w_retry_inc;
  logic        w_cc_latched;
  logic        w_cc_other;
  logic        w_fail;
  logic        r_vbus_en;
  logic        r_auth_start;
  logic        r_link_ready;
  logic        r_auth_locked;

  // The CC pin chosen at attach is the one watched for detach. The other pin
  // has to stay quiet during debounce.
  assign w_cc_latched = r_orient ? bus.cc2_rd : bus.cc1_rd;
  assign w_cc_other   = r_orient ? bus.cc1_rd : bus.cc2_rd;
  assign w_retry_inc  = r_retry + 4'd1;

  // Next-state decision. A detach on the latched CC is tested first in every
  // state that watches CC, so it beats auth results and timeouts. Recovery
  // deliberately ignores CC so that VBUS always gets its full off-time.
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    case (r_state)
      ST_UNATTACHED: begin
        if (bus.cc1_rd ^ bus.cc2_rd) w_next = ST_ATTACH_WAIT;
      end
      ST_ATTACH_WAIT: begin
        if (!w_cc_latched || w_cc_other) w_next = ST_UNATTACHED;
        else if (r_timer == DEB_LAST)    w_next = ST_POWER_ON;
      end
      ST_POWER_ON: begin
        if (!w_cc_latched)               w_next = ST_UNATTACHED;
        else if (bus.vbus_good)          w_next = ST_AUTH_REQ;
        else if (r_timer == VBUS_LAST)   w_next = ST_ERROR_RECOVERY;
      end
      ST_AUTH_REQ: begin
        if (!w_cc_latched) w_next = ST_UNATTACHED;
        else               w_next = ST_AUTH_WAIT;
      end
      ST_AUTH_WAIT: begin
        if (!w_cc_latched) begin
          w_next = ST_UNATTACHED;
        end else if (bus.auth_done && bus.auth_pass) begin
          w_next = ST_LINK_UP;
        end else if (bus.auth_done || (r_timer == AUTH_LAST)) begin
          w_fail = 1'b1;
          w_next = (w_retry_inc < MAX_R) ? ST_AUTH_REQ : ST_LOCKOUT;
        end
      end
      ST_LINK_UP, ST_LOCKOUT: begin
        if (!w_cc_latched) w_next = ST_UNATTACHED;
      end
      ST_ERROR_RECOVERY: begin
        if (r_timer == REC_LAST) w_next = ST_UNATTACHED;
      end
      default: w_next = ST_UNATTACHED;
    endcase
  end

  // All state is kept here: the state register, the shared timer (it restarts
  // on every state change), the orientation and retry count (both latched at
  // attach), and the registered outputs. The outputs are decoded from the
  // next state so they line up with the cycle the new state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_UNATTACHED;
      r_timer       <= 16'd0;
      r_orient      <= 1'b0;
      r_retry       <= 4'd0;
      r_vbus_en     <= 1'b0;
      r_auth_start  <= 1'b0;
      r_link_ready  <= 1'b0;
      r_auth_locked <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state) ? 16'd0 : r_timer + 16'd1;
      if ((r_state == ST_UNATTACHED) && (w_next == ST_ATTACH_WAIT)) begin
        r_orient <= bus.cc2_rd;
        r_retry  <= 4'd0;
      end else if (w_fail) begin
        r_retry  <= w_retry_inc;
      end
      r_vbus_en     <= (w_next == ST_POWER_ON) || (w_next == ST_AUTH_REQ) ||
                       (w_next == ST_AUTH_WAIT) || (w_next == ST_LINK_UP);
      r_auth_start  <= (w_next == ST_AUTH_REQ);
      r_link_ready  <= (w_next == ST_LINK_UP);
      r_auth_locked <= (w_next == ST_LOCKOUT);
    end
  end

  assign bus.vbus_en     = r_vbus_en;
  assign bus.orient      = r_orient;
  assign bus.auth_start  = r_auth_start;
  assign bus.link_ready  = r_link_ready;
  assign bus.auth_locked = r_auth_locked;
  assign bus.state_o     = r_state;
  assign bus.retry_cnt   = r_retry;

endmodule

// File: doc/usb_typec_attach_ctrl.md
# usb_typec_attach_ctrl

Sequencing controller for the USB Type-C receptacle on the device side. It detects a sink/source attach on CC1/CC2 and debounces it. It then latches cable orientation, enables VBUS and waits for VBUS good, and starts the authentication driver with bounded retries and timeout. Outputs are link-ready, lockout and error-recovery indications. It sits between the CC comparators/VBUS switch and the authentication FSM, next to the host model on the Type-C pin bus.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: cycles a single CC must be stable before attach is accepted (1..65535)
- VBUS_TIMEOUT, 8: max cycles in POWER_ON waiting for vbus_good (1..65535)
- AUTH_TIMEOUT, 16: max cycles in AUTH_WAIT waiting for auth_done (1..65535)
- MAX_RETRIES, 2: authentication attempts allowed before lockout (1..15)
- RECOVERY_CYCLES, 6: cycles VBUS is held off in ERROR_RECOVERY (1..65535)

Ports:
- clk  input  1  single system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- cc1_rd  input  1  CC1 termination detected (pre-synchronised level)
- cc2_rd  input  1  CC2 termination detected (pre-synchronised level)
- vbus_good  input  1  VBUS within valid range
- auth_done  input  1  one-cycle pulse from authentication FSM: result valid
- auth_pass  input  1  authentication result, sampled only with auth_done
- vbus_en  output  1  VBUS switch enable
- orient  output  1  0 = CC1 active, 1 = CC2 active (lane mux select)
- auth_start  output  1  one-cycle pulse: start authentication
- link_ready  output  1  attached, powered, authenticated
- auth_locked  output  1  retries exhausted
- state_o  output  3  current state encoding
- retry_cnt  output  4  failed attempts in current attach

## Operation

States (state_o encoding): UNATTACHED=0, ATTACH_WAIT=1, POWER_ON=2, AUTH_REQ=3, AUTH_WAIT=4, LINK_UP=5, LOCKOUT=6, ERROR_RECOVERY=7.

A single 16-bit timer is shared by all states and cleared on every state change.

- **UNATTACHED:** all outputs low. If exactly one of cc1_rd/cc2_rd is high, latch orient (cc2_rd), clear retry_cnt and go to ATTACH_WAIT. Both high or both low: stay.
- **ATTACH_WAIT:** the latched CC must stay high and the other CC low every cycle; any deviation goes to UNATTACHED. When timer == DEBOUNCE_CYCLES-1, go to POWER_ON; otherwise increment the timer.
- **POWER_ON:** vbus_en=1. If vbus_good, go to AUTH_REQ. Else if timer == VBUS_TIMEOUT-1, go to ERROR_RECOVERY.
- **AUTH_REQ:** auth_start=1 for exactly this one cycle, vbus_en=1. Next state is AUTH_WAIT.
- **AUTH_WAIT:** vbus_en=1.
  - auth_done & auth_pass: go to LINK_UP.
  - auth_done & !auth_pass, or timer == AUTH_TIMEOUT-1 without auth_done: increment retry_cnt. If the new count < MAX_RETRIES, go to AUTH_REQ; else go to LOCKOUT.
  - auth_done has priority over timeout in the same cycle.
- **LINK_UP:** vbus_en=1, link_ready=1. The state is held until detach.
- **LOCKOUT:** vbus_en=0, auth_locked=1. The state is held until detach.
- **ERROR_RECOVERY:** vbus_en=0. When timer == RECOVERY_CYCLES-1, go to UNATTACHED.

Detach rule:
- In POWER_ON, AUTH_REQ, AUTH_WAIT, LINK_UP and LOCKOUT, the latched CC low goes to UNATTACHED.
- Detach has priority over every other transition, including auth_done and timeouts.
- ERROR_RECOVERY ignores CC and always completes its hold-off.

General rules:
- auth_done outside AUTH_WAIT is ignored.
- vbus_good loss after POWER_ON is ignored by this block.
- orient stays at its latched value until the next attach latch, including in UNATTACHED.

## Timing

- Reset values: state UNATTACHED, timer 0, vbus_en 0, orient 0, auth_start 0, link_ready 0, auth_locked 0, retry_cnt 0, state_o 0.
- All outputs are decoded from registered state/counters. They change in the first cycle the state register holds the new state. There are no combinational input-to-output paths.
- Attach latency:
  - cc1_rd sampled high at edge 0 puts ATTACH_WAIT in cycles 1..DEBOUNCE_CYCLES.
  - vbus_en rises in cycle DEBOUNCE_CYCLES+1.
- vbus_good sampled high in POWER_ON cycle n gives auth_start high in cycle n+1 and AUTH_WAIT in cycle n+2.
- Retry: a failing auth_done in cycle n gives auth_start again in cycle n+1.
- Detach sampled at edge k: vbus_en and link_ready are low in cycle k+1.
- reset asserted at any point returns every register to its reset value on the next edge. This includes mid-debounce and mid-authentication.

## Test plan

1. **Clean attach, pass.** cc1_rd=1 held, vbus_good high 2 cycles after vbus_en, auth_done+auth_pass 5 cycles after auth_start -> orient=0, vbus_en rises 5 cycles after cc1_rd, one auth_start pulse, link_ready=1, retry_cnt=0.
2. **Bounce and illegal CC.** cc2_rd high 3 cycles then low -> returns to UNATTACHED, vbus_en never rises. Both CCs high -> stays UNATTACHED. Then cc2_rd held -> orient=1, POWER_ON after 4 cycles.
3. **Retry then lockout.** Two auth_done with auth_pass=0 -> retry_cnt 1 then 2, second auth_start 1 cycle after first fail, LOCKOUT with auth_locked=1 and vbus_en=0. cc1_rd low -> UNATTACHED, retry_cnt cleared on next attach.
4. **Timeouts.** vbus_good never asserted -> ERROR_RECOVERY after 8 POWER_ON cycles, vbus_en low 6 cycles, then UNATTACHED. AUTH_WAIT with no auth_done -> retry after 16 cycles. auth_done coincident with the timeout cycle -> treated as result (pass -> LINK_UP).
5. **Detach priority.** Latched CC drops in the same cycle as auth_done+auth_pass -> UNATTACHED, link_ready never asserted. Detach from LINK_UP -> vbus_en low next cycle.
6. **Reset mid-operation.** reset pulsed in AUTH_WAIT -> all outputs at reset values next cycle. With cc1_rd still high, a full new debounce is required before vbus_en rises.
